// File: rtl/shmem_arbiter.sv
// shmem_arbiter
// Round-robin arbiter that shares one single-port shared_memory among NUM_PE
// processing elements. It accepts one request per cycle. Read data returns one
// cycle after the grant. Addresses at or above MEM_DEPTH never reach the memory;
// they get an error response instead.
// Optional feature: define SHMEM_ARB_LOCK_EN to add the pe_lock port. A PE can
// then hold the arbiter for up to MAX_LOCK consecutive grants, for
// read-modify-write sequences.
module shmem_arbiter #(
  parameter int NUM_PE    = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 256,
  parameter int MAX_LOCK  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_PE-1:0]        pe_req,
  input  logic [NUM_PE-1:0]        pe_we,
  input  logic [NUM_PE*ADDR_W-1:0] pe_addr,
  input  logic [NUM_PE*DATA_W-1:0] pe_wdata,
`ifdef SHMEM_ARB_LOCK_EN
  input  logic [NUM_PE-1:0]        pe_lock,
`endif
  output logic [NUM_PE-1:0]        pe_gnt,
  output logic [NUM_PE-1:0]        pe_rvalid,
  output logic [NUM_PE-1:0]        pe_err,
  output logic [DATA_W-1:0]        pe_rdata,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_read,
  output logic                     mem_write,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  // Stop elaboration on an unsupported configuration.
  if (NUM_PE < 2 || NUM_PE > 16 || MAX_LOCK < 1) begin : g_bad_param
    $error("shmem_arbiter: NUM_PE must be 2..16 and MAX_LOCK >= 1");
  end

  // The response slot is captured at grant time and consumed one cycle later.
  typedef struct packed {
    logic             vld;  // a grant happened last cycle
    logic             rd;   // it was a read, so pe_rvalid fires
    logic             err;  // its address was out of range
    logic [PTR_W-1:0] id;   // the PE that owns the response
  } rsp_t;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  rsp_t              rsp_q, rsp_d;
  logic [NUM_PE-1:0] req_eff;
  logic              gnt_any;
  logic [PTR_W-1:0]  win_id;
  logic [PTR_W:0]    cand_sum;
  logic [PTR_W-1:0]  cand;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              win_we;
  logic              win_inr;

`ifdef SHMEM_ARB_LOCK_EN
  localparam int LCK_W = $clog2(MAX_LOCK + 1);
  logic             lock_q, lock_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [LCK_W-1:0] cnt_q, cnt_d, cnt_next;
  logic             lock_active;

  // The lock holds only while its owner keeps requesting.
  assign lock_active = rst_n && lock_q && pe_req[owner_q];
`endif

  // Winner select: the first requester at or after ptr, wrapping around.
  // NOTE: every variable written in an always_comb gets a default first, so no
  // latch can be inferred on any path.
  always_comb begin
    req_eff  = rst_n ? pe_req : '0;
`ifdef SHMEM_ARB_LOCK_EN
    if (lock_active) req_eff = pe_req & (NUM_PE'(1) << owner_q);
`endif
    gnt_any  = 1'b0;
    win_id   = '0;
    cand_sum = '0;
    cand     = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      cand_sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (cand_sum >= (PTR_W+1)'(NUM_PE)) cand_sum = cand_sum - (PTR_W+1)'(NUM_PE);
      cand = cand_sum[PTR_W-1:0];
      if (!gnt_any && req_eff[cand]) begin
        gnt_any = 1'b1;
        win_id  = cand;
      end
    end
  end

  // Grant, memory strobes, next pointer and the response slot for the winner.
  always_comb begin
    win_addr  = pe_addr[int'(win_id)*ADDR_W +: ADDR_W];
    win_wdata = pe_wdata[int'(win_id)*DATA_W +: DATA_W];
    win_we    = pe_we[win_id];
    win_inr   = win_addr < ADDR_W'(MEM_DEPTH);
    pe_gnt    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ptr_d     = ptr_q;
    rsp_d     = '0;
    if (gnt_any) begin
      pe_gnt[win_id] = 1'b1;
      mem_addr       = win_addr;
      mem_wdata      = win_wdata;
      mem_read       = !win_we && win_inr;
      mem_write      = win_we && win_inr;
      // While locked the winner is always the owner, so this keeps ptr at
      // owner+1, which is also its value after a forced release.
      ptr_d          = (win_id == PTR_W'(NUM_PE-1)) ? '0 : win_id + PTR_W'(1);
      rsp_d.vld      = 1'b1;
      rsp_d.rd       = !win_we;
      rsp_d.err      = !win_inr;
      rsp_d.id       = win_id;
    end
  end

  // Response outputs. They are gated by rst_n, so a response that falls in a
  // reset cycle is dropped.
  always_comb begin
    pe_rvalid = '0;
    pe_err    = '0;
    pe_rdata  = '0;
    if (rst_n && rsp_q.vld) begin
      pe_rvalid[rsp_q.id] = rsp_q.rd;
      pe_err[rsp_q.id]    = rsp_q.err;
      if (rsp_q.rd && !rsp_q.err) pe_rdata = mem_rdata;
    end
  end

  // Arbitration pointer and response slot registers.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its pre-edge value. Reset is sampled synchronously on the clock
  // edge and clears only control state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      rsp_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      rsp_q <= rsp_d;
    end
  end

`ifdef SHMEM_ARB_LOCK_EN
  // Lock bookkeeping. The locking grant counts as the first of MAX_LOCK.
  always_comb begin
    lock_d   = lock_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    cnt_next = lock_active ? cnt_q + LCK_W'(1) : LCK_W'(1);
    if (lock_q && !pe_req[owner_q]) begin
      lock_d = 1'b0;
      cnt_d  = '0;
    end
    if (gnt_any) begin
      if (pe_lock[win_id] && cnt_next < LCK_W'(MAX_LOCK)) begin
        lock_d  = 1'b1;
        owner_d = win_id;
        cnt_d   = cnt_next;
      end else begin
        lock_d = 1'b0;
        cnt_d  = '0;
      end
    end
  end

  // Lock state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_q  <= 1'b0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_shmem_arbiter.sv
// tb_shmem_arbiter
// Directed bench for shmem_arbiter with NUM_PE=4 and MEM_DEPTH=256. It runs a
// word-array memory emulator behind the DUT. A cycle-level reference model
// predicts every output on each falling edge. Hand-computed literal checks pin
// the test-plan scenarios. Define SHMEM_ARB_LOCK_EN to add the lock scenario.
module tb_shmem_arbiter;

  localparam int NUM_PE   = 4;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 256;
  localparam int MAX_LOCK = 8;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_PE-1:0]        pe_req, pe_we, pe_lock;
  logic [NUM_PE*ADDR_W-1:0] pe_addr;
  logic [NUM_PE*DATA_W-1:0] pe_wdata;
  logic [NUM_PE-1:0]        pe_gnt, pe_rvalid, pe_err;
  logic [DATA_W-1:0]        pe_rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0]        mem_addr;
  logic                     mem_read, mem_write;

  int total = 0;
  int bad   = 0;

  shmem_arbiter #(
    .NUM_PE(NUM_PE), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .MEM_DEPTH(DEPTH), .MAX_LOCK(MAX_LOCK)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pe_req(pe_req), .pe_we(pe_we), .pe_addr(pe_addr), .pe_wdata(pe_wdata),
`ifdef SHMEM_ARB_LOCK_EN
    .pe_lock(pe_lock),
`endif
    .pe_gnt(pe_gnt), .pe_rvalid(pe_rvalid), .pe_err(pe_err), .pe_rdata(pe_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory emulator: one-cycle-latency read, write on the strobe edge.
  logic [DATA_W-1:0] emu_mem [0:DEPTH-1];
  initial begin
    for (int a = 0; a < DEPTH; a++) emu_mem[a] = 32'h1000_0000 + 32'(a);
    forever begin
      @(posedge clk);
      if (mem_write) emu_mem[mem_addr[7:0]] <= mem_wdata;
      mem_rdata <= mem_read ? emu_mem[mem_addr[7:0]] : 32'hA5A5_A5A5;
    end
  end

  // Reference model: arbitration rules applied to the current inputs, plus a
  // record of last cycle's transaction and a shadow copy of memory contents.
  logic [DATA_W-1:0] shadow [0:DEPTH-1];
  int          m_ptr, m_owner, m_cnt, m_rsp_id, win;
  logic        m_locked, m_rsp_v, m_rsp_rd, m_rsp_err, we_w, inr;
  logic [31:0] m_rsp_data, a, d, e_addr, e_wd, e_rd;
  logic [3:0]  e_gnt, e_rv, e_err;
  logic        e_mr, e_mw;

  initial begin
    for (int i = 0; i < DEPTH; i++) shadow[i] = 32'h1000_0000 + 32'(i);
    m_ptr = 0; m_owner = 0; m_cnt = 0; m_locked = 1'b0;
    m_rsp_v = 1'b0; m_rsp_id = 0; m_rsp_rd = 1'b0; m_rsp_err = 1'b0; m_rsp_data = '0;
    we_w = 1'b0; inr = 1'b0; a = '0; d = '0;
    forever begin
      @(negedge clk);
      e_rv = '0; e_err = '0; e_rd = '0;
      if (rst_n && m_rsp_v) begin
        e_rv[m_rsp_id]  = m_rsp_rd;
        e_err[m_rsp_id] = m_rsp_err;
        e_rd = (m_rsp_rd && !m_rsp_err) ? m_rsp_data : 32'h0;
      end
      win = -1;
      if (rst_n) begin
        if (m_locked && pe_req[m_owner]) win = m_owner;
        else begin
          m_locked = 1'b0;
          m_cnt    = 0;
          for (int k = 0; k < NUM_PE; k++)
            if (win < 0 && pe_req[(m_ptr + k) % NUM_PE]) win = (m_ptr + k) % NUM_PE;
        end
      end
      e_gnt = '0; e_addr = '0; e_wd = '0; e_mr = 1'b0; e_mw = 1'b0;
      if (win >= 0) begin
        a = pe_addr[win*ADDR_W +: ADDR_W];
        d = pe_wdata[win*DATA_W +: DATA_W];
        we_w = pe_we[win];
        inr  = a < DEPTH;
        e_gnt[win] = 1'b1;
        e_addr = a; e_wd = d;
        e_mr = !we_w && inr;
        e_mw = we_w && inr;
      end
      check("m_gnt",       32'(pe_gnt),    32'(e_gnt));
      check("m_mem_addr",  mem_addr,       e_addr);
      check("m_mem_wdata", mem_wdata,      e_wd);
      check("m_mem_read",  32'(mem_read),  32'(e_mr));
      check("m_mem_write", 32'(mem_write), 32'(e_mw));
      check("m_rvalid",    32'(pe_rvalid), 32'(e_rv));
      check("m_err",       32'(pe_err),    32'(e_err));
      check("m_rdata",     pe_rdata,       e_rd);
      if (!rst_n) begin
        m_ptr = 0; m_locked = 1'b0; m_cnt = 0; m_rsp_v = 1'b0;
      end else begin
        m_rsp_v = (win >= 0);
        if (win >= 0) begin
          m_rsp_id = win; m_rsp_rd = !we_w; m_rsp_err = !inr;
          m_rsp_data = inr ? shadow[a[7:0]] : 32'h0;
          if (we_w && inr) shadow[a[7:0]] = d;
          m_ptr = (win + 1) % NUM_PE;
          if (m_locked && win == m_owner) begin
            if (pe_lock[win]) begin
              m_cnt++;
              if (m_cnt >= MAX_LOCK) begin m_locked = 1'b0; m_cnt = 0; end
            end else begin
              m_locked = 1'b0; m_cnt = 0;
            end
          end else if (pe_lock[win]) begin
            m_locked = 1'b1; m_owner = win; m_cnt = 1;
            if (m_cnt >= MAX_LOCK) begin m_locked = 1'b0; m_cnt = 0; end
          end
        end
      end
    end
  end

  // Stimulus helpers: each cycle's inputs change 1 time unit after the rising edge.
  task automatic clear_all();
    pe_req = '0; pe_we = '0; pe_lock = '0; pe_addr = '0; pe_wdata = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    clear_all();
  endtask

  task automatic drive(input int i, input logic we, input logic [31:0] ad, input logic [31:0] wd);
    pe_req[i] = 1'b1;
    pe_we[i]  = we;
    pe_addr[i*ADDR_W +: ADDR_W]  = ad;
    pe_wdata[i*DATA_W +: DATA_W] = wd;
  endtask

  localparam logic [3:0] MIX_REQ [6] = '{4'b0110, 4'b1001, 4'b1111, 4'b0000, 4'b0101, 4'b1100};
  localparam logic [3:0] MIX_WE  [6] = '{4'b0100, 4'b0001, 4'b1010, 4'b0000, 4'b0001, 4'b1000};
  localparam logic       LOCK_PE1 [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    rst_n = 1'b0;
    clear_all();
    pe_req = '1;
    // Reset: requests are ignored and every output is 0.
    cyc(); pe_req = '1; #2;
    check("rst_gnt",      32'(pe_gnt),   32'h0);
    check("rst_mem_read", 32'(mem_read), 32'h0);
    check("rst_rvalid",   32'(pe_rvalid), 32'h0);
    // Single read: PE2 writes 0xDEADBEEF to 5, then reads it back.
    cyc(); rst_n = 1'b1; drive(2, 1'b1, 32'd5, 32'hDEAD_BEEF); #2;
    check("wr_gnt",       32'(pe_gnt),    32'h4);
    check("wr_mem_write", 32'(mem_write), 32'h1);
    check("wr_mem_addr",  mem_addr,       32'd5);
    check("wr_mem_wdata", mem_wdata,      32'hDEAD_BEEF);
    cyc(); drive(2, 1'b0, 32'd5, 32'h0); #2;
    check("rd_gnt",       32'(pe_gnt),   32'h4);
    check("rd_mem_read",  32'(mem_read), 32'h1);
    check("wr_no_rvalid", 32'(pe_rvalid), 32'h0);
    cyc(); #2;
    check("rd_rvalid", 32'(pe_rvalid), 32'h4);
    check("rd_rdata",  pe_rdata,       32'hDEAD_BEEF);
    // Wrap-around: ptr is now 3. PE3 wins before PE0.
    cyc(); drive(0, 1'b0, 32'd6, 32'h0); drive(3, 1'b0, 32'd7, 32'h0); #2;
    check("wrap_gnt_a", 32'(pe_gnt), 32'h8);
    cyc(); drive(0, 1'b0, 32'd6, 32'h0); #2;
    check("wrap_gnt_b",  32'(pe_gnt),    32'h1);
    check("wrap_rvalid", 32'(pe_rvalid), 32'h8);
    check("wrap_rdata",  pe_rdata,       32'h1000_0007);
    // Out-of-range read 256, write 300, then the 255 boundary.
    cyc(); drive(1, 1'b0, 32'd256, 32'h0); #2;
    check("oor_rd_gnt",    32'(pe_gnt),               32'h2);
    check("oor_rd_strobe", 32'({mem_read, mem_write}), 32'h0);
    check("wrap_rdata_b",  pe_rdata,                  32'h1000_0006);
    cyc(); drive(1, 1'b1, 32'd300, 32'h1234); #2;
    check("oor_wr_strobe", 32'({mem_read, mem_write}), 32'h0);
    check("oor_rd_err",    32'(pe_err),    32'h2);
    check("oor_rd_rvalid", 32'(pe_rvalid), 32'h2);
    check("oor_rd_rdata",  pe_rdata,       32'h0);
    cyc(); drive(1, 1'b0, 32'd255, 32'h0); #2;
    check("edge_mem_read", 32'(mem_read),  32'h1);
    check("edge_mem_addr", mem_addr,       32'd255);
    check("oor_wr_err",    32'(pe_err),    32'h2);
    check("oor_wr_rvalid", 32'(pe_rvalid), 32'h0);
    cyc(); #2;
    check("edge_rvalid", 32'(pe_rvalid), 32'h2);
    check("edge_rdata",  pe_rdata,       32'h1000_00FF);
    // Mixed request/write patterns near the range boundary; the model checks these.
    for (int c = 0; c < 6; c++) begin
      cyc();
      for (int i = 0; i < NUM_PE; i++)
        if (MIX_REQ[c][i]) drive(i, MIX_WE[c][i], 32'(250 + i*3 + c), 32'hC0DE_0000 + 32'(c*16 + i));
    end
    // Reset in the response cycle of PE0's read.
    cyc(); drive(0, 1'b0, 32'd7, 32'h0); #2;
    check("mid_gnt", 32'(pe_gnt), 32'h1);
    cyc(); rst_n = 1'b0; pe_req = '1; #2;
    check("mid_rvalid",   32'(pe_rvalid), 32'h0);
    check("mid_gnt_rst",  32'(pe_gnt),    32'h0);
    check("mid_mem_read", 32'(mem_read),  32'h0);
    check("mid_mem_addr", mem_addr,       32'h0);
    check("mid_err",      32'(pe_err),    32'h0);
    check("mid_rdata",    pe_rdata,       32'h0);
    // Fairness from reset: order 0,1,2,3,0,1,2,3; each read answers next cycle.
    for (int c = 0; c < 8; c++) begin
      cyc();
      rst_n = 1'b1;
      for (int i = 0; i < NUM_PE; i++) drive(i, 1'b0, 32'(10 + i), 32'h0);
      #2;
      check("fair_gnt", 32'(pe_gnt), 32'(1 << (c % 4)));
      if (c > 0) check("fair_rvalid", 32'(pe_rvalid), 32'(1 << ((c - 1) % 4)));
    end
`ifdef SHMEM_ARB_LOCK_EN
    // Lock: PE1 holds the arbiter for 8 grants, then PE0 gets through.
    for (int c = 0; c < 10; c++) begin
      cyc();
      drive(0, 1'b0, 32'd20, 32'h0);
      drive(1, 1'b0, 32'd21, 32'h0);
      pe_lock[1] = 1'b1;
      #2;
      check("lock_gnt", 32'(pe_gnt), LOCK_PE1[c] ? 32'h2 : 32'h1);
    end
`endif
    cyc();
    cyc();
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
